// File: rtl/bpsk_burst_sequencer.sv
// BPSK burst sequencer: alternating preamble followed by MSB-first payload bits,
// each bit expanded to sps samples on an AXI-Stream master, with gap and repeat.
module bpsk_burst_sequencer #(
    parameter int PREAMBLE_LEN = 32,
    parameter int LEN_W        = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_loop,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [7:0]       cfg_sps,
    input  logic [LEN_W-1:0] cfg_gap,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic             m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] BYTE_LAST = 8'd7;

    state_t           state_q, state_d;
    logic [7:0]       sps_q, sps_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
    logic [7:0]       samp_q, samp_d;
    logic [7:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       buf_q, buf_d;
    logic             buf_vld_q, buf_vld_d;
    logic             tvalid_q, tvalid_d;
    logic             tdata_q, tdata_d;
    logic             tlast_q, tlast_d;
    logic             tready_q, tready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;

    logic       m_hs, s_hs, last_samp, bit_wrap, burst_end, gap_end;
    logic       byte_avail;
    logic [7:0] byte_in;
    logic [7:0] sps_m1_d;
    logic       need_byte, finish, restart, consumed;

    assign m_hs       = tvalid_q & m_axis_tready;
    assign s_hs       = tready_q & s_axis_tvalid;
    assign last_samp  = (samp_q == sps_q - 8'd1);
    assign bit_wrap   = m_hs & last_samp;
    assign burst_end  = bit_wrap & (((state_q == PREAMBLE) & (bit_q == PRE_LAST) & (len_q == '0)) |
                                    ((state_q == PAYLOAD) & (bit_q == BYTE_LAST) & (bytes_left_q == '0)));
    assign gap_end    = (state_q == GAP) & ((gap_q == '0) | (gap_cnt_q == gap_q - LEN_W'(1)));
    // A byte accepted earlier waits in buf_q; otherwise a live handshake feeds the shifter directly.
    assign byte_avail = buf_vld_q | s_hs;
    assign byte_in    = buf_vld_q ? buf_q : s_axis_tdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            sps_q        <= 8'd1;
            len_q        <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            bytes_left_q <= '0;
            samp_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            buf_q        <= '0;
            buf_vld_q    <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= 1'b0;
            tlast_q      <= 1'b0;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sps_q        <= sps_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            bytes_left_q <= bytes_left_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            buf_q        <= buf_d;
            buf_vld_q    <= buf_vld_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tready_q     <= tready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cfg_start) state_d = PREAMBLE;
            PREAMBLE: if (bit_wrap && bit_q == PRE_LAST) state_d = (len_q != '0) ? PAYLOAD : GAP;
            PAYLOAD:  if (burst_end) state_d = GAP;
            GAP:      if (gap_end) state_d = cfg_loop ? PREAMBLE : IDLE;
            default:  state_d = IDLE;
        endcase
        if (cfg_abort) state_d = IDLE;
    end

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        sps_d        = sps_q;
        len_d        = len_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        bytes_left_d = bytes_left_q;
        samp_d       = samp_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        buf_d        = buf_q;
        buf_vld_d    = buf_vld_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        underrun_d   = underrun_q;
        done_d       = 1'b0;
        need_byte    = 1'b0;
        finish       = 1'b0;
        restart      = 1'b0;
        consumed     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    sps_d      = (cfg_sps == 8'd0) ? 8'd1 : cfg_sps;
                    len_d      = cfg_len;
                    gap_d      = cfg_gap;
                    underrun_d = 1'b0;
                    restart    = 1'b1;
                end
            end
            PREAMBLE: begin
                if (m_hs) begin
                    if (!last_samp) begin
                        samp_d = samp_q + 8'd1;
                    end else begin
                        samp_d = '0;
                        if (bit_q != PRE_LAST) begin
                            bit_d   = bit_q + 8'd1;
                            tdata_d = ~tdata_q;
                        end else if (len_q != '0) begin
                            need_byte = 1'b1;
                        end else begin
                            finish = 1'b1;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!tvalid_q) begin
                    need_byte = 1'b1;
                end else if (m_hs) begin
                    if (!last_samp) begin
                        samp_d = samp_q + 8'd1;
                    end else begin
                        samp_d = '0;
                        if (bit_q != BYTE_LAST) begin
                            bit_d   = bit_q + 8'd1;
                            tdata_d = shreg_q[7];
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end else if (bytes_left_q == '0) begin
                            finish = 1'b1;
                        end else begin
                            need_byte = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + LEN_W'(1);
                if (gap_end && cfg_loop) restart = 1'b1;
            end
            default: ;
        endcase

        // Starvation holds tvalid low before the new bit is ever offered.
        if (need_byte) begin
            bit_d = '0;
            if (byte_avail) begin
                tdata_d      = byte_in[7];
                shreg_d      = {byte_in[6:0], 1'b0};
                tvalid_d     = 1'b1;
                bytes_left_d = bytes_left_q - LEN_W'(1);
                buf_vld_d    = 1'b0;
                consumed     = 1'b1;
            end else begin
                tvalid_d   = 1'b0;
                underrun_d = 1'b1;
            end
        end
        if (finish) begin
            tvalid_d  = 1'b0;
            done_d    = 1'b1;
            gap_cnt_d = '0;
        end
        if (restart) begin
            samp_d       = '0;
            bit_d        = '0;
            bytes_left_d = len_d;
            tvalid_d     = 1'b1;
            tdata_d      = 1'b1;
            buf_vld_d    = 1'b0;
            gap_cnt_d    = '0;
        end
        if (s_hs && !consumed) begin
            buf_d     = s_axis_tdata;
            buf_vld_d = 1'b1;
        end
        if (cfg_abort) begin
            tvalid_d     = 1'b0;
            tdata_d      = 1'b0;
            samp_d       = '0;
            bit_d        = '0;
            bytes_left_d = '0;
            shreg_d      = '0;
            buf_vld_d    = 1'b0;
            gap_cnt_d    = '0;
            done_d       = 1'b0;
        end
    end

    // Registered outputs are computed from next-state values so they align with the state they describe.
    always_comb begin
        sps_m1_d = sps_d - 8'd1;
        busy_d   = (state_d != IDLE);
        tready_d = ((state_d == PREAMBLE) || (state_d == PAYLOAD)) && (bytes_left_d != '0) && !buf_vld_d &&
                   (!tvalid_d || ((samp_d == sps_m1_d) &&
                                  (((state_d == PREAMBLE) && (bit_d == PRE_LAST)) ||
                                   ((state_d == PAYLOAD) && (bit_d == BYTE_LAST)))));
        tlast_d  = tvalid_d && (samp_d == sps_m1_d) &&
                   (((state_d == PREAMBLE) && (bit_d == PRE_LAST) && (len_d == '0)) ||
                    ((state_d == PAYLOAD) && (bit_d == BYTE_LAST) && (bytes_left_d == '0)));
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_bpsk_burst_sequencer.sv
// Directed bench for bpsk_burst_sequencer: a vector table of whole bursts plus
// hand-written sequences for underrun, abort, looping, ignored start and async reset.
module tb_bpsk_burst_sequencer;

    localparam int PL    = 32;
    localparam int LEN_W = 16;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             cfg_start = 1'b0, cfg_abort = 1'b0, cfg_loop = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0, cfg_gap = '0;
    logic [7:0]       cfg_sps = '0;
    logic [7:0]       s_axis_tdata = '0;
    logic             s_axis_tvalid = 1'b0, s_axis_tready;
    logic             m_axis_tdata, m_axis_tvalid, m_axis_tlast;
    logic             m_axis_tready = 1'b1;
    logic             busy, done, underrun;

    always #5 aclk = ~aclk;

    bpsk_burst_sequencer #(.PREAMBLE_LEN(PL), .LEN_W(LEN_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_loop(cfg_loop),
        .cfg_len(cfg_len), .cfg_sps(cfg_sps), .cfg_gap(cfg_gap),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .underrun(underrun)
    );

    typedef struct {
        logic [15:0] len;
        logic [7:0]  sps;
        logic [7:0]  b0;
        logic [7:0]  b1;
        bit          bp;
        int          exp_samples;
        int          exp_tlast;
        logic [15:0] exp_bits;
    } vec_t;

    vec_t       vecs[5];
    int         n_checks = 0, n_fail = 0;
    logic       samp_q[$];
    int         tlast_at[$];
    logic [7:0] src_q[$];
    int         done_cnt = 0, hold_err = 0;
    bit         bp_en = 1'b0, src_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor at negedge, source and backpressure drive just after posedge.
    initial begin : monitor_driver
        bit   s_pop, prev_stall;
        logic prev_data, prev_last;
        s_pop = 0; prev_stall = 0; prev_data = 0; prev_last = 0;
        forever begin
            @(negedge aclk);
            s_pop = 0;
            if (!aresetn) begin
                prev_stall = 0;
            end else begin
                if (prev_stall && !(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last))
                    hold_err++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready) begin
                    samp_q.push_back(m_axis_tdata);
                    if (m_axis_tlast) tlast_at.push_back(samp_q.size());
                end
                if (done) done_cnt++;
                s_pop = s_axis_tvalid && s_axis_tready;
            end
            @(posedge aclk);
            #1;
            if (s_pop && src_q.size() > 0) void'(src_q.pop_front());
            s_axis_tvalid = !src_hold && (src_q.size() > 0);
            s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : 8'h00;
            m_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic drive_wait();
        @(posedge aclk);
        #2;
    endtask

    task automatic start_burst(input logic [15:0] len, input logic [7:0] sps, input logic [15:0] gap, input bit loop);
        drive_wait();
        samp_q.delete();
        tlast_at.delete();
        done_cnt  = 0;
        hold_err  = 0;
        cfg_len   = len;
        cfg_sps   = sps;
        cfg_gap   = gap;
        cfg_loop  = loop;
        cfg_start = 1'b1;
        drive_wait();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        check(name, done, 1);
    endtask

    task automatic wait_samples(input int cnt, input int limit, input string name);
        int n = 0;
        while (samp_q.size() < cnt && n < limit) begin
            tick();
            n++;
        end
        check(name, (samp_q.size() >= cnt), 1);
    endtask

    // Expected stream: preamble 1,0,1,0,... then the payload bits MSB first from bits[15].
    function automatic int mismatches(input int sps, input logic [15:0] bits);
        int m = 0;
        for (int i = 0; i < samp_q.size(); i++) begin
            int   b;
            logic e;
            b = i / sps;
            if (b < PL)           e = (b % 2 == 0);
            else if (b - PL < 16) e = bits[15 - (b - PL)];
            else                  e = 1'bx;
            if (samp_q[i] !== e) m++;
        end
        return m;
    endfunction

    function automatic int last_pos(input int idx);
        return (tlast_at.size() > idx) ? tlast_at[idx] : -1;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int idle, n, m, hi, eff;

        vecs[0] = '{16'd2, 8'd1, 8'hA5, 8'h3C, 1'b0,  48,  48, 16'hA53C};
        vecs[1] = '{16'd1, 8'd4, 8'hF0, 8'h00, 1'b1, 160, 160, 16'hF000};
        vecs[2] = '{16'd0, 8'd0, 8'h00, 8'h00, 1'b0,  32,  32, 16'h0000};
        vecs[3] = '{16'd2, 8'd2, 8'h81, 8'h7E, 1'b1,  96,  96, 16'h817E};
        vecs[4] = '{16'd0, 8'd3, 8'h00, 8'h00, 1'b0,  96,  96, 16'h0000};

        repeat (3) tick();
        check("reset_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, busy, done, underrun}, 0);
        drive_wait();
        aresetn = 1'b1;
        tick();
        check("post_reset_idle", {m_axis_tvalid, busy, s_axis_tready}, 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].len >= 1) src_q.push_back(vecs[i].b0);
            if (vecs[i].len >= 2) src_q.push_back(vecs[i].b1);
            eff = (vecs[i].sps == 8'd0) ? 1 : int'(vecs[i].sps);
            start_burst(vecs[i].len, vecs[i].sps, 16'd0, 1'b0);
            bp_en = vecs[i].bp;
            if (i == 0) begin
                tick();
                check("start_latency", {busy, m_axis_tvalid, m_axis_tdata}, 3'b111);
            end
            wait_done(4000, $sformatf("v%0d_done", i));
            bp_en = 1'b0;
            tick();
            check($sformatf("v%0d_busy_low", i), busy, 0);
            check($sformatf("v%0d_samples", i), samp_q.size(), vecs[i].exp_samples);
            check($sformatf("v%0d_tlast_cnt", i), tlast_at.size(), 1);
            check($sformatf("v%0d_tlast_pos", i), last_pos(0), vecs[i].exp_tlast);
            check($sformatf("v%0d_data", i), mismatches(eff, vecs[i].exp_bits), 0);
            check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("v%0d_hold", i), hold_err, 0);
            check($sformatf("v%0d_underrun", i), underrun, 0);
        end

        // Underrun: byte withheld past the preamble, then released.
        src_hold = 1'b1;
        src_q.push_back(8'h5A);
        start_burst(16'd1, 8'd1, 16'd0, 1'b0);
        wait_samples(32, 200, "ur_preamble");
        hi = 0;
        repeat (10) begin
            tick();
            if (m_axis_tvalid) hi++;
        end
        check("ur_stall_tvalid", hi, 0);
        check("ur_flag", underrun, 1);
        drive_wait();
        src_hold = 1'b0;
        wait_done(100, "ur_done");
        check("ur_samples", samp_q.size(), 40);
        check("ur_data", mismatches(1, 16'h5A00), 0);
        tick();
        check("ur_sticky", underrun, 1);
        start_burst(16'd0, 8'd1, 16'd0, 1'b0);
        tick();
        check("ur_cleared", underrun, 0);
        wait_done(100, "ur2_done");
        tick();

        // Abort in the middle of byte 0, then a clean burst.
        src_q.push_back(8'hA5);
        src_q.push_back(8'h3C);
        start_burst(16'd2, 8'd1, 16'd0, 1'b0);
        wait_samples(37, 200, "ab_reach");
        drive_wait();
        cfg_abort = 1'b1;
        drive_wait();
        cfg_abort = 1'b0;
        tick();
        check("ab_outputs", {m_axis_tvalid, busy, s_axis_tready}, 0);
        repeat (20) tick();
        check("ab_no_done", done_cnt, 0);
        check("ab_no_tlast", tlast_at.size(), 0);
        src_q.delete();
        src_q.push_back(8'hC3);
        start_burst(16'd1, 8'd1, 16'd0, 1'b0);
        wait_done(200, "ab_rerun_done");
        check("ab_rerun_samples", samp_q.size(), 40);
        check("ab_rerun_data", mismatches(1, 16'hC300), 0);
        check("ab_rerun_tlast", last_pos(0), 40);
        tick();

        // Loop mode, preamble only, gap of 3; loop cleared during the second burst.
        start_burst(16'd0, 8'd1, 16'd3, 1'b1);
        n = 0;
        while (tlast_at.size() < 1 && n < 200) begin
            tick();
            n++;
        end
        check("loop_first_tlast", last_pos(0), 32);
        idle = 0;
        n = 0;
        tick();
        while (!m_axis_tvalid && n < 50) begin
            idle++;
            tick();
            n++;
        end
        check("loop_gap_cycles", idle, 3);
        check("loop_restart_tdata", m_axis_tdata, 1);
        drive_wait();
        cfg_loop = 1'b0;
        wait_done(200, "loop_second_done");
        repeat (10) tick();
        check("loop_end_idle", {busy, m_axis_tvalid}, 0);
        check("loop_samples", samp_q.size(), 64);
        check("loop_tlast_pos2", last_pos(1), 64);
        check("loop_done_cnt", done_cnt, 2);
        m = 0;
        for (int i = 0; i < samp_q.size(); i++)
            if (samp_q[i] !== ((i % PL) % 2 == 0)) m++;
        check("loop_data", m, 0);

        // cfg_start during PAYLOAD must not disturb the running burst.
        src_q.push_back(8'h96);
        start_burst(16'd1, 8'd1, 16'd0, 1'b0);
        wait_samples(34, 200, "ign_reach");
        drive_wait();
        cfg_len   = 16'd5;
        cfg_sps   = 8'd3;
        cfg_start = 1'b1;
        drive_wait();
        cfg_start = 1'b0;
        wait_done(200, "ign_done");
        check("ign_samples", samp_q.size(), 40);
        check("ign_tlast", last_pos(0), 40);
        check("ign_data", mismatches(1, 16'h9600), 0);
        tick();
        check("ign_idle", busy, 0);

        // Asynchronous reset mid-burst clears outputs without waiting for an edge.
        src_q.push_back(8'h11);
        start_burst(16'd1, 8'd1, 16'd0, 1'b0);
        wait_samples(10, 100, "rst_reach");
        #2;
        aresetn = 1'b0;
        #1;
        check("rst_async_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, busy, done}, 0);
        drive_wait();
        aresetn = 1'b1;
        src_q.delete();
        start_burst(16'd0, 8'd1, 16'd0, 1'b0);
        wait_done(100, "rst_rerun_done");
        check("rst_rerun_samples", samp_q.size(), 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bpsk_burst_sequencer.md
# bpsk_burst_sequencer

Sequences BPSK burst transmission for the `axi_bpsk_ctrl` subsystem. A start command and configuration fields from the AXI4-Lite register bank launch a burst: a fixed alternating preamble, then payload bytes pulled MSB-first from an AXI-Stream source. Each bit is expanded to a programmable number of samples and delivered to the modulator over an AXI-Stream master port. The block adds a programmable inter-burst gap and an optional repeat mode.

## Interface
- PREAMBLE_LEN, 32: preamble length in bits (1..255); pattern 1,0,1,0,…
- LEN_W, 16: width of payload length and gap fields
- aclk  in  1  clock; all logic on the rising edge
- aresetn  in  1  asynchronous, active-low reset
- cfg_start  in  1  single-cycle start pulse; honoured only in IDLE
- cfg_abort  in  1  single-cycle abort pulse; honoured in any state
- cfg_loop  in  1  repeat the burst after the gap; sampled live at end of GAP
- cfg_len  in  LEN_W  payload length in bytes; latched at start
- cfg_sps  in  8  samples per bit; latched at start; 0 treated as 1
- cfg_gap  in  LEN_W  idle cycles after a burst; latched at start
- s_axis_tdata  in  8  payload byte
- s_axis_tvalid  in  1  payload byte valid
- s_axis_tready  out  1  byte accepted when tvalid & tready
- m_axis_tdata  out  1  sample: 1 = +1, 0 = −1
- m_axis_tvalid  out  1  sample valid
- m_axis_tready  in  1  modulator ready
- m_axis_tlast  out  1  last sample of the burst
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last sample handshake
- underrun  out  1  sticky; set on payload starvation; cleared by the next accepted cfg_start

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, GAP.
- IDLE + cfg_start: latch len/sps/gap, clear underrun, go to PREAMBLE.
- PREAMBLE: emit PREAMBLE_LEN bits, each held for sps samples.
  - After the last preamble sample: go to PAYLOAD if len > 0, else GAP.
- PAYLOAD:
  - 8-bit shift register, MSB first; byte counter counts down from len.
  - When the shift register is empty and a bit is needed, assert s_axis_tready and load the byte on handshake.
  - If no byte is present, m_axis_tvalid stays low and underrun sets. The stall persists until a byte arrives; the burst is not truncated.
  - After the last bit of byte len−1: go to GAP.
- GAP: count gap cycles, then:
  - cfg_loop = 1: go to PREAMBLE with the same latched config.
  - cfg_loop = 0: go to IDLE.
  - gap = 0: the transition is taken on the first GAP cycle.
- Sample counter runs 0..sps−1 and advances only on m_axis_tvalid & m_axis_tready. The bit advances when the counter wraps.
- m_axis_tlast is high on the final sample of the final bit: the last payload bit, or the last preamble bit when len = 0.
- done pulses in the cycle after the tlast handshake, every burst, including loops.
- cfg_abort: next state IDLE from any state.
  - m_axis_tvalid and s_axis_tready drop the next cycle.
  - Shift register and counters clear; no tlast; no done.
  - Abort takes priority over a simultaneous start or a state transition.
- cfg_start outside IDLE is ignored.

## Timing
- All outputs are registered. Reset values: m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, s_axis_tready 0, busy 0, done 0, underrun 0; state IDLE.
- Latency: cfg_start at cycle N gives busy = 1 and m_axis_tvalid = 1 (tdata = 1) at cycle N+1.
- Throughput: one sample per cycle while m_axis_tready = 1. Burst length in samples = (PREAMBLE_LEN + 8·len)·sps.
- AXI-Stream: once asserted, m_axis_tvalid, tdata and tlast hold until the handshake. Abort is the only exception. Underrun stalls occur only before valid is raised for a new bit.
- Payload prefetch: the next byte is requested during the last sample of the current bit. Back-to-back bits then have no bubble when the source is ready.
- busy falls the cycle after entering IDLE.
- Counters are unsigned. len = 2^LEN_W − 1 must not overflow.
- Reset mid-burst: all outputs return to reset values immediately, asynchronously.

## Test plan
- len = 2, sps = 1, gap = 0, loop = 0, bytes 0xA5 then 0x3C, tready = 1:
  - 32 preamble samples 1010…, then samples 10100101 00111100.
  - tlast on sample 48; done one cycle later; busy low the following cycle.
- sps = 4, len = 1, byte 0xF0: each bit repeated 4 times; 160 samples total. Random m_axis_tready backpressure: data stable while stalled; sample count unchanged.
- len = 1, source withholds the byte for 10 cycles after the preamble:
  - tvalid low for those cycles; underrun = 1 and stays 1.
  - Burst then completes normally.
  - Next cfg_start clears underrun.
- cfg_abort mid-payload (bit 5 of byte 0):
  - tvalid 0 next cycle; no tlast; no done; busy 0.
  - A following start runs a full burst from the preamble.
- loop = 1, gap = 3, len = 0: preamble-only bursts with tlast on each last preamble sample and exactly 3 idle cycles between bursts. Clear loop during a burst: that burst ends in IDLE.
- len = 0 with sps = 0: treated as sps = 1, 32 samples. cfg_start during PAYLOAD: ignored, config unchanged.
